// File: rtl/gpu_pixel_queue.sv
// Pixel-write queue: buffers CPU {addr, data} stores and drains them to the GPU
// framebuffer write port only in cycles where the GPU accepts a write.
module gpu_pixel_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     flush_i,
  input  logic                     drain_ok_i,
  input  logic                     clr_ovf_i,
  output logic                     v_we_o,
  output logic [ADDR_W-1:0]        v_addr_o,
  output logic [DATA_W-1:0]        v_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              v_we_q;
  logic [ADDR_W-1:0] v_addr_q;
  logic [DATA_W-1:0] v_data_q;

  logic full, empty, pop, push, drop;

  // Status comes from the registered count only, so no input reaches these outputs.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // When full, a push is still accepted if a pop frees a slot in the same cycle.
  assign pop  = !empty && drain_ok_i && !flush_i;
  assign push = wr_en_i && !flush_i && (!full || pop);
  assign drop = wr_en_i && !flush_i && full && !pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    // Set wins over a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Control state and registered output stage.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      v_we_q   <= 1'b0;
      v_addr_q <= '0;
      v_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      v_we_q   <= pop;
      if (pop) begin
        v_addr_q <= addr_mem_q[rd_ptr_q];
        v_data_q <= data_mem_q[rd_ptr_q];
      end
    end
  end

  // Entry storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= wr_addr_i;
      data_mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign v_we_o     = v_we_q;
  assign v_addr_o   = v_addr_q;
  assign v_data_o   = v_data_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule
